multicycle_control: RTL and testbench

- Sequential successor to the combinational Control decoder: a Moore FSM that sequences the multicycle datapath through fetch, decode, execute, memory and writeback.
- Emits the same datapath controls: IorD, memw, regw, pcw, srw, aluop, regop, aluSrcA, aluSrcB, compcodew.
- Adds irw, pcsrc, memory wait-state handshake, branch/jump support and illegal-opcode trapping.
- Sits between the instruction register opcode field and the datapath muxes and enables.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and the datapath it steers.
// master: the controller (drives control lines, observes opcode/status).
// slave : the datapath side (drives opcode/status, observes control lines).
interface multicycle_control_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                cond_true;
  logic                IorD;
  logic                memw;
  logic                irw;
  logic                regw;
  logic                pcw;
  logic                srw;
  logic                compcodew;
  logic [ALUOP_W-1:0]  aluop;
  logic [1:0]          regop;
  logic [1:0]          aluSrcA;
  logic [1:0]          aluSrcB;
  logic [1:0]          pcsrc;
  logic                illegal;
  logic [3:0]          state;

  modport master (
    input  opcode, mem_ready, cond_true,
    output IorD, memw, irw, regw, pcw, srw, compcodew, aluop, regop,
           aluSrcA, aluSrcB, pcsrc, illegal, state
  );

  modport slave (
    output opcode, mem_ready, cond_true,
    input  IorD, memw, irw, regw, pcw, srw, compcodew, aluop, regop,
           aluSrcA, aluSrcB, pcsrc, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle datapath: fetch, decode, execute,
// memory and writeback, with memory wait states and illegal-opcode trapping.
module multicycle_control #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 2,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StStart    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWrite = 4'd5,
    StMemWb    = 4'd6,
    StAluExec  = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StIllegal  = 4'd11
  } state_e;

  state_e state_q, state_d;
  // ALU function captured in DECODE so later opcode changes cannot affect it.
  logic [1:0] fn_q, fn_d;

  logic [OPCODE_W-1:0] opcode;
  logic [3:0]          op4;
  logic                upper_ok;
  logic                ready;
  logic                is_lw, is_sw, is_alu, is_beq, is_jmp;
  logic [1:0]          aluop2;
  logic [ALUOP_W-1:0]  aluop_w;

  assign opcode = bus.opcode;
  assign op4    = opcode[3:0];
  assign ready  = bus.mem_ready | ~MEM_WAIT_EN;

  // Any set bit above [3:0] makes the opcode illegal.
  if (OPCODE_W > 4) begin : g_upper
    assign upper_ok = ~|opcode[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign upper_ok = 1'b1;
  end

  assign is_lw  = upper_ok & (op4 == 4'b0000);
  assign is_sw  = upper_ok & (op4 == 4'b0001);
  assign is_alu = upper_ok & (op4[3:2] == 2'b01);
  assign is_beq = upper_ok & (op4 == 4'b1000);
  assign is_jmp = upper_ok & (op4 == 4'b1001);

  // State and latched ALU function; reset forces START at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStart;
      fn_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StStart;
    fn_d    = fn_q;
    case (state_q)
      StStart:    state_d = StFetch;
      StFetch:    state_d = ready ? StDecode : StFetch;
      StDecode: begin
        fn_d = op4[1:0];
        if (is_lw || is_sw)  state_d = StMemAddr;
        else if (is_alu)     state_d = StAluExec;
        else if (is_beq)     state_d = StBranch;
        else if (is_jmp)     state_d = StJump;
        else                 state_d = StIllegal;
      end
      StMemAddr: begin
        if (is_sw)      state_d = StMemWrite;
        else if (is_lw) state_d = StMemRead;
        else            state_d = StIllegal;
      end
      StMemRead:  state_d = ready ? StMemWb : StMemRead;
      StMemWrite: state_d = ready ? StFetch : StMemWrite;
      StMemWb:    state_d = StFetch;
      StAluExec:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StStart;
    endcase
  end

  // Moore output decode; only FETCH (ready) and BRANCH (cond_true) are qualified.
  always_comb begin
    bus.IorD      = 1'b0;
    bus.memw      = 1'b0;
    bus.irw       = 1'b0;
    bus.regw      = 1'b0;
    bus.pcw       = 1'b0;
    bus.srw       = 1'b0;
    bus.compcodew = 1'b0;
    bus.regop     = 2'd0;
    bus.aluSrcA   = 2'd0;
    bus.aluSrcB   = 2'd0;
    bus.pcsrc     = 2'd0;
    bus.illegal   = 1'b0;
    aluop2        = 2'd0;
    case (state_q)
      StFetch: begin
        bus.aluSrcB = 2'd1;
        bus.irw     = ready;
        bus.pcw     = ready;
      end
      StDecode: begin
        bus.aluSrcB = 2'd2;
      end
      StMemAddr: begin
        bus.aluSrcA = 2'd1;
        bus.aluSrcB = 2'd2;
      end
      StMemRead: begin
        bus.IorD = 1'b1;
      end
      StMemWrite: begin
        bus.IorD = 1'b1;
        bus.memw = 1'b1;
      end
      StMemWb: begin
        bus.regw  = 1'b1;
        bus.regop = 2'd1;
      end
      StAluExec: begin
        bus.aluSrcA   = 2'd1;
        aluop2        = fn_q;
        bus.srw       = 1'b1;
        bus.compcodew = 1'b1;
      end
      StAluWb: begin
        bus.regw = 1'b1;
      end
      StBranch: begin
        bus.aluSrcA   = 2'd1;
        aluop2        = 2'd1;
        bus.compcodew = 1'b1;
        bus.pcsrc     = 2'd1;
        bus.pcw       = bus.cond_true;
      end
      StJump: begin
        bus.pcsrc = 2'd2;
        bus.pcw   = 1'b1;
      end
      StIllegal: begin
        bus.illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluop_w   = ALUOP_W'(aluop2);
  assign bus.aluop = aluop_w;
  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each step drives inputs, pushes
// the expected output snapshot, then pops and compares it before the next edge.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(4), .ALUOP_W(2)) bus ();

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(2), .MEM_WAIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memw, irw, regw, pcw, srw, ccw;
    logic [1:0] aluop, regop, srca, srcb, pcsrc;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [3:0] op;
    logic       rdy;
    logic       cond;
    logic [3:0] st;
    logic [1:0] fn;
  } step_t;

  out_t  sb_q[$];
  step_t step_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Expected outputs for one cycle, taken from the per-state output table.
  function automatic out_t exp_out(input logic [3:0] st, input logic [1:0] fn,
                                   input logic cond, input logic rdy);
    out_t o;
    o = '0;
    o.st = st;
    case (st)
      4'd1:  begin o.srcb = 2'd1; o.irw = rdy; o.pcw = rdy; end
      4'd2:  o.srcb = 2'd2;
      4'd3:  begin o.srca = 2'd1; o.srcb = 2'd2; end
      4'd4:  o.iord = 1'b1;
      4'd5:  begin o.iord = 1'b1; o.memw = 1'b1; end
      4'd6:  begin o.regw = 1'b1; o.regop = 2'd1; end
      4'd7:  begin o.srca = 2'd1; o.aluop = fn; o.srw = 1'b1; o.ccw = 1'b1; end
      4'd8:  o.regw = 1'b1;
      4'd9:  begin
        o.srca = 2'd1; o.aluop = 2'd1; o.ccw = 1'b1; o.pcsrc = 2'd1; o.pcw = cond;
      end
      4'd10: begin o.pcsrc = 2'd2; o.pcw = 1'b1; end
      4'd11: o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.st    = bus.state;
    o.iord  = bus.IorD;
    o.memw  = bus.memw;
    o.irw   = bus.irw;
    o.regw  = bus.regw;
    o.pcw   = bus.pcw;
    o.srw   = bus.srw;
    o.ccw   = bus.compcodew;
    o.aluop = bus.aluop;
    o.regop = bus.regop;
    o.srca  = bus.aluSrcA;
    o.srcb  = bus.aluSrcB;
    o.pcsrc = bus.pcsrc;
    o.ill   = bus.illegal;
    return o;
  endfunction

  task automatic add(input logic [3:0] op, input logic rdy, input logic cond,
                     input logic [3:0] st, input logic [1:0] fn);
    step_t s;
    s.op = op; s.rdy = rdy; s.cond = cond; s.st = st; s.fn = fn;
    step_q.push_back(s);
  endtask

  // Starts and ends at a negedge; leaves the DUT in FETCH.
  task automatic test_reset();
    out_t got, want;
    rst = 1'b1;
    bus.opcode = 4'b0100; bus.mem_ready = 1'b1; bus.cond_true = 1'b1;
    sb_q.push_back(exp_out(4'd0, 2'd0, 1'b1, 1'b1));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_held: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(exp_out(4'd0, 2'd0, 1'b1, 1'b1));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_release_start: got %h want %h", got, want);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    step_t s; out_t got, want; int i;
    add(4'b0000, 1, 0, 4'd1, 0); add(4'b0000, 1, 0, 4'd2, 0);
    add(4'b0000, 1, 0, 4'd3, 0); add(4'b0000, 1, 0, 4'd4, 0);
    add(4'b0000, 1, 0, 4'd6, 0);
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL lw step %0d: got %h want %h", i, got, want);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    step_t s; out_t got, want; int i;
    add(4'b0001, 1, 0, 4'd1, 0); add(4'b0001, 1, 0, 4'd2, 0);
    add(4'b0001, 1, 0, 4'd3, 0);
    add(4'b0000, 0, 0, 4'd5, 0); add(4'b1111, 0, 1, 4'd5, 0);
    add(4'b0000, 0, 0, 4'd5, 0); add(4'b0000, 1, 0, 4'd5, 0);
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL sw_wait step %0d: got %h want %h", i, got, want);
      end
      i++;
      @(negedge clk);
    end
  endtask

  // FETCH wait cycle, then sub; opcode changes after DECODE must not alter aluop.
  task automatic test_alu_sub();
    step_t s; out_t got, want; int i;
    add(4'b0101, 0, 0, 4'd1, 0); add(4'b0101, 1, 0, 4'd1, 0);
    add(4'b0101, 1, 0, 4'd2, 0); add(4'b0111, 1, 0, 4'd7, 2'd1);
    add(4'b0011, 1, 0, 4'd8, 0);
    add(4'b0110, 1, 0, 4'd1, 0); add(4'b0110, 1, 0, 4'd2, 0);
    add(4'b0000, 1, 0, 4'd7, 2'd2); add(4'b0000, 1, 0, 4'd8, 0);
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL alu step %0d: got %h want %h", i, got, want);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch_jump();
    step_t s; out_t got, want; int i;
    add(4'b1000, 1, 1, 4'd1, 0); add(4'b1000, 1, 1, 4'd2, 0);
    add(4'b1000, 1, 0, 4'd9, 0);
    add(4'b1000, 1, 0, 4'd1, 0); add(4'b1000, 1, 0, 4'd2, 0);
    add(4'b1000, 1, 1, 4'd9, 0);
    add(4'b1001, 1, 0, 4'd1, 0); add(4'b1001, 1, 0, 4'd2, 0);
    add(4'b0000, 0, 0, 4'd10, 0);
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL branch_jump step %0d: got %h want %h", i, got, want);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset_wait();
    step_t s; out_t got, want; int i;
    add(4'b0000, 1, 0, 4'd1, 0); add(4'b0000, 1, 0, 4'd2, 0);
    add(4'b0000, 1, 0, 4'd3, 0); add(4'b0000, 0, 0, 4'd4, 0);
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL async_rst step %0d: got %h want %h", i, got, want);
      end
      i++;
      if (step_q.size() > 0) @(negedge clk);
    end
    // Still mid-wait in MEM_READ, well before the next rising edge.
    #1 rst = 1'b1;
    sb_q.push_back(exp_out(4'd0, 2'd0, 1'b0, 1'b0));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL async_rst_immediate: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0;
    sb_q.push_back(exp_out(4'd0, 2'd0, 1'b0, 1'b0));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL async_rst_release: got %h want %h", got, want);
    end
    @(negedge clk);
    sb_q.push_back(exp_out(4'd1, 2'd0, 1'b0, 1'b0));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL async_rst_resume_fetch: got %h want %h", got, want);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    step_t s; out_t got, want; int i;
    add(4'b0011, 1, 0, 4'd1, 0); add(4'b0011, 1, 0, 4'd2, 0);
    for (int k = 0; k < 20; k++) begin
      add(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)), 4'd11, 0);
    end
    i = 0;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      bus.opcode = s.op; bus.mem_ready = s.rdy; bus.cond_true = s.cond;
      sb_q.push_back(exp_out(s.st, s.fn, s.cond, s.rdy));
      #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL illegal step %0d: got %h want %h", i, got, want);
      end
      i++;
      @(negedge clk);
    end
    rst = 1'b1;
    sb_q.push_back(exp_out(4'd0, 2'd0, 1'b0, 1'b1));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL illegal_cleared_by_rst: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    sb_q.push_back(exp_out(4'd1, 2'd0, 1'b0, 1'b1));
    #1; want = sb_q.pop_front(); got = dut_out(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL illegal_resume_fetch: got %h want %h", got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.cond_true = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_sub();
    test_branch_jump();
    test_async_reset_wait();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
